// File: rtl/sad_search_if.sv
// Handshake bundle between the SAD search controller, the motion-search top
// level (go/done/best) and the SAD datapath control pins.
interface sad_search_if #(
  parameter int NUM_CAND = 8,
  parameter int BLK_SIZE = 16,
  parameter int SAD_W    = 16
);
  localparam int ADDR_W = $clog2(BLK_SIZE);
  localparam int CAND_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  logic              go;
  logic [SAD_W-1:0]  sad_in;
  logic              AB_rd;
  logic [ADDR_W-1:0] addr_i;
  logic [CAND_W-1:0] cand_idx;
  logic              sum_clr;
  logic              sum_ld;
  logic              sad_reg_ld;
  logic              busy;
  logic              done;
  logic [SAD_W-1:0]  best_sad;
  logic [CAND_W-1:0] best_idx;

  // Controller side
  modport master (
    input  go, sad_in,
    output AB_rd, addr_i, cand_idx, sum_clr, sum_ld, sad_reg_ld,
           busy, done, best_sad, best_idx
  );

  // Top-level / datapath side
  modport slave (
    output go, sad_in,
    input  AB_rd, addr_i, cand_idx, sum_clr, sum_ld, sad_reg_ld,
           busy, done, best_sad, best_idx
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// Multi-candidate SAD search sequencer: for each candidate clears the
// accumulator, streams BLK_SIZE reads, drains the datapath pipe, loads the
// SAD register and keeps the strict minimum (earliest index wins ties).
module sad_search_ctrl #(
  parameter int NUM_CAND = 8,
  parameter int BLK_SIZE = 16,
  parameter int SAD_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  sad_search_if.master  bus
);
  localparam int ADDR_W = $clog2(BLK_SIZE);
  localparam int CAND_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int DRN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLK_SIZE - 1);
  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NUM_CAND - 1);
  localparam logic [DRN_W-1:0]  DRN_INIT  = (PIPE_LAT > 0) ? DRN_W'(PIPE_LAT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, CLR, READ, DRAIN, CAPTURE, CMP, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [CAND_W-1:0] best_idx_q, best_idx_d;
  logic              ab_rd;

  // Next-state, counters and best tracking
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    cand_d     = cand_q;
    drn_d      = drn_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d    = CLR;
          cand_d     = '0;
          best_sad_d = '1;
          best_idx_d = '0;
        end
      end
      CLR: begin
        addr_d  = '0;
        state_d = READ;
      end
      READ: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          drn_d   = DRN_INIT;
          state_d = (PIPE_LAT == 0) ? CAPTURE : DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == '0) state_d = CAPTURE;
        else             drn_d   = drn_q - 1'b1;
      end
      CAPTURE: state_d = CMP;
      CMP: begin
        // Strict compare: ties keep the earlier candidate
        if (bus.sad_in < best_sad_q) begin
          best_sad_d = bus.sad_in;
          best_idx_d = cand_q;
        end
        if (cand_q == CAND_LAST) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = CLR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cand_q     <= '0;
      drn_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cand_q     <= cand_d;
      drn_q      <= drn_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Strobes decode from registered state only
  assign ab_rd          = (state_q == READ);
  assign bus.AB_rd      = ab_rd;
  assign bus.addr_i     = addr_q;
  assign bus.cand_idx   = cand_q;
  assign bus.sum_clr    = (state_q == CLR);
  assign bus.sad_reg_ld = (state_q == CAPTURE);
  assign bus.busy       = (state_q == CLR) || (state_q == READ) || (state_q == DRAIN) ||
                          (state_q == CAPTURE) || (state_q == CMP);
  assign bus.done       = (state_q == DONE);
  assign bus.best_sad   = best_sad_q;
  assign bus.best_idx   = best_idx_q;

  // sum_ld is AB_rd delayed by the datapath latency, independent of state
  if (PIPE_LAT == 0) begin : g_no_pipe
    assign bus.sum_ld = ab_rd;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;

    // Shift AB_rd into the delay line
    always_comb begin
      pipe_d[0] = ab_rd;
      for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Delay line register, cleared by reset so an abort leaves no stray sum_ld
    always_ff @(posedge clk) begin
      if (!rst) pipe_q <= '0;
      else      pipe_q <= pipe_d;
    end

    assign bus.sum_ld = pipe_q[PIPE_LAT-1];
  end
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed, table-driven bench for sad_search_ctrl: default-parameter
// instance for full searches plus a NUM_CAND=1/PIPE_LAT=0 instance.
module tb_sad_search_ctrl;
  localparam int NC     = 8;
  localparam int BLK    = 16;
  localparam int LAT    = 2;
  localparam int P      = BLK + LAT + 3;
  localparam int DONE_N = 1 + NC * P;

  typedef struct packed {
    logic [7:0][15:0] sads;   // concatenation lists candidate 7 first
    logic [15:0]      best;
    logic [2:0]       idx;
    logic [1:0]       mode;   // 0: single go pulse, 2: extra go pulses while busy
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0][15:0] cur_sads = '0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sad_search_if #(.NUM_CAND(NC), .BLK_SIZE(BLK), .SAD_W(16)) bus ();
  sad_search_if #(.NUM_CAND(1),  .BLK_SIZE(BLK), .SAD_W(16)) bus1 ();

  assign bus.sad_in  = cur_sads[bus.cand_idx];
  assign bus1.sad_in = 16'h1234;

  sad_search_ctrl #(.NUM_CAND(NC), .BLK_SIZE(BLK), .SAD_W(16), .PIPE_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  sad_search_ctrl #(.NUM_CAND(1), .BLK_SIZE(BLK), .SAD_W(16), .PIPE_LAT(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.AB_rd, bus.addr_i, bus.cand_idx, bus.sum_clr, bus.sum_ld,
            bus.sad_reg_ld, bus.busy, bus.done, bus.best_sad, bus.best_idx};
  endfunction

  // Starts a search at the current negedge and follows it cycle by cycle
  // against a timing model; abort_at > 0 pulls reset in that cycle instead.
  task automatic run_search(input logic [7:0][15:0] sads, input logic [15:0] exp_best,
                            input logic [2:0] exp_idx, input int mode, input int abort_at,
                            input string tag);
    int n_ab, n_sl, n_sr, n_sc, done_at, terr, k, o;
    logic e_busy, e_ab, e_sl, e_sc, e_sr;
    logic [3:0] e_addr;
    logic [15:0] got_best;
    logic [2:0] got_idx;
    n_ab = 0; n_sl = 0; n_sr = 0; n_sc = 0; done_at = 0; terr = 0;
    got_best = '0; got_idx = '0;
    cur_sads = sads;
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    if (mode != 1) bus.go = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (abort_at > 0 && n == abort_at + 1) begin
        check({tag, " reset outputs"}, all_outs(), 32'h0);
        check({tag, " no done before abort"}, done_at, 0);
        check({tag, " trace before abort"}, terr, 0);
        rst = 1'b1;
        return;
      end
      k = (n - 1) / P;
      o = (n - 1) % P;
      e_busy = (n < DONE_N);
      e_ab   = e_busy && o >= 1 && o <= BLK;
      e_sl   = e_busy && o >= 1 + LAT && o <= BLK + LAT;
      e_sc   = e_busy && o == 0;
      e_sr   = e_busy && o == BLK + LAT + 1;
      e_addr = e_ab ? 4'(o - 1) : 4'd0;
      if (bus.AB_rd !== e_ab || bus.sum_ld !== e_sl || bus.sum_clr !== e_sc ||
          bus.sad_reg_ld !== e_sr || bus.busy !== e_busy || bus.done !== (n == DONE_N) ||
          bus.addr_i !== e_addr || (e_busy && bus.cand_idx !== 3'(k))) begin
        if (terr == 0) $display("trace divergence (%s) at cycle t+%0d", tag, n);
        terr++;
      end
      n_ab += int'(bus.AB_rd);
      n_sl += int'(bus.sum_ld);
      n_sr += int'(bus.sad_reg_ld);
      n_sc += int'(bus.sum_clr);
      if (mode == 2) bus.go = (n == 50 || n == 100 || n == DONE_N);
      if (n == abort_at) rst = 1'b0;
      if (bus.done) begin
        done_at  = n;
        got_best = bus.best_sad;
        got_idx  = bus.best_idx;
        break;
      end
    end
    check({tag, " done cycle"}, done_at, DONE_N);
    check({tag, " best_sad"}, got_best, exp_best);
    check({tag, " best_idx"}, got_idx, exp_idx);
    check({tag, " trace"}, terr, 0);
    check({tag, " AB_rd count"}, n_ab, NC * BLK);
    check({tag, " sum_ld count"}, n_sl, NC * BLK);
    check({tag, " sad_reg_ld count"}, n_sr, NC);
    check({tag, " sum_clr count"}, n_sc, NC);
  endtask

  // Two idle cycles after DONE: no restart, best values held
  task automatic check_idle_after(input logic [15:0] exp_best, input string tag);
    @(negedge clk);
    bus.go = 1'b0;
    check({tag, " idle after done"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, " still idle"}, {bus.busy, bus.done}, 2'b00);
    check({tag, " best_sad held"}, bus.best_sad, exp_best);
  endtask

  vec_t tbl[6];

  initial begin
    int ab1, err1, done1;
    logic [15:0] best1;
    logic [0:0] idx1;

    tbl[0] = '{sads: {16'd20, 16'd70, 16'd10, 16'd90, 16'd10, 16'd45, 16'd40, 16'd50},
               best: 16'd10, idx: 3'd3, mode: 2'd0};
    tbl[1] = '{sads: {8{16'hFFFF}}, best: 16'hFFFF, idx: 3'd0, mode: 2'd0};
    tbl[2] = '{sads: {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80},
               best: 16'd10, idx: 3'd7, mode: 2'd2};
    tbl[3] = '{sads: {8{16'd5}}, best: 16'd5, idx: 3'd0, mode: 2'd0};
    tbl[4] = '{sads: {16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF},
               best: 16'hFFFE, idx: 3'd1, mode: 2'd0};
    tbl[5] = '{sads: {16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1},
               best: 16'd0, idx: 3'd7, mode: 2'd0};

    bus.go  = 1'b0;
    bus1.go = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", all_outs(), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle after reset", all_outs(), 32'h0);

    for (int i = 0; i < 6; i++) begin
      run_search(tbl[i].sads, tbl[i].best, tbl[i].idx, int'(tbl[i].mode), 0, $sformatf("vec%0d", i));
      check_idle_after(tbl[i].best, $sformatf("vec%0d", i));
    end

    // go held high through a whole search, then straight into a second one
    run_search(tbl[0].sads, 16'd10, 3'd3, 1, 0, "hold1");
    @(negedge clk);
    check("hold idle between searches", bus.busy, 1'b0);
    run_search({16'd155, 16'd150, 16'd160, 16'd170, 16'd180, 16'd200, 16'd250, 16'd300},
               16'd150, 3'd6, 0, 0, "hold2");
    check_idle_after(16'd150, "hold2");

    // reset during READ of candidate 4, then a clean full search
    run_search(tbl[0].sads, 16'd10, 3'd3, 0, 4 * P + 6, "abort");
    run_search(tbl[0].sads, 16'd10, 3'd3, 0, 0, "after_abort");
    check_idle_after(16'd10, "after_abort");

    // single candidate, zero pipeline latency
    ab1 = 0; err1 = 0; done1 = 0; best1 = '0; idx1 = '1;
    bus1.go = 1'b1;
    @(posedge clk);
    #1;
    bus1.go = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus1.sum_ld !== bus1.AB_rd) err1++;
      ab1 += int'(bus1.AB_rd);
      if (bus1.done) begin
        done1 = n;
        best1 = bus1.best_sad;
        idx1  = bus1.best_idx;
        break;
      end
    end
    check("single done cycle", done1, 1 + BLK + 3);
    check("single best_sad", best1, 16'h1234);
    check("single best_idx", idx1, 1'b0);
    check("single AB_rd count", ab1, BLK);
    check("single sum_ld follows AB_rd", err1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
